// File: rtl/fifo_stream_reader_pkg.sv
// rtl/fifo_stream_reader_pkg.sv - shared FIFO status type, skid-buffer states and helpers
package fifo_stream_reader_pkg;

   typedef struct packed {
      logic full;
      logic empty;
   } fill_status_t;

   localparam logic [1:0] BUF_EMPTY = 2'd0;
   localparam logic [1:0] BUF_ONE   = 2'd1;
   localparam logic [1:0] BUF_TWO   = 2'd2;

   // A burst of one word still needs a 1-bit counter to keep the vector legal.
   function automatic int burst_cnt_width(input int burst_len);
      return (burst_len > 1) ? $clog2(burst_len) : 1;
   endfunction

endpackage

// File: rtl/fifo_connect_if.sv
// rtl/fifo_connect_if.sv - fifoConnect interface between a fifo and its reader/writer
interface fifoConnect
   import fifo_stream_reader_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32
);
   localparam int LEVEL_W = $clog2(DEPTH + 1);

   logic               read;
   logic               write;
   logic [WIDTH-1:0]   datain;
   logic [WIDTH-1:0]   dataout;
   fill_status_t       fillStatus;
   logic [LEVEL_W-1:0] fillLevel;

   modport reader (
      output read,
      output write,
      output datain,
      input  dataout,
      input  fillStatus
   );

   modport fifo (
      input  read,
      input  write,
      input  datain,
      output dataout,
      output fillStatus,
      output fillLevel
   );

endinterface

// File: rtl/fifo_stream_reader_skid_buffer_2.sv
// rtl/fifo_stream_reader_skid_buffer_2.sv - 2-entry register skid buffer with push/pop and occupancy
module skid_buffer_2
   import fifo_stream_reader_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [1:0]       occ,
   output logic             valid
);

   logic [1:0]       state;
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] tail_q;

   // Head is only rewritten on a pop or into an empty buffer, so it holds while stalled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= BUF_EMPTY;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         case (state)
            BUF_EMPTY: begin
               if (push) begin
                  head_q <= push_data;
                  state  <= BUF_ONE;
               end
            end
            BUF_ONE: begin
               case ({push, pop})
                  2'b10: begin
                     tail_q <= push_data;
                     state  <= BUF_TWO;
                  end
                  2'b01: state <= BUF_EMPTY;
                  2'b11: head_q <= push_data;
                  default: ;
               endcase
            end
            BUF_TWO: begin
               if (pop) begin
                  head_q <= tail_q;
                  if (push) begin
                     tail_q <= push_data;
                  end else begin
                     state <= BUF_ONE;
                  end
               end
            end
            default: state <= BUF_EMPTY;
         endcase
      end
   end

   assign head_data = head_q;
   assign occ       = state;
   assign valid     = (state != BUF_EMPTY);

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - fifo reader to valid/ready stream; FIFO_READER_BURST_EN enables m_last
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 32,
   parameter int BURST_LEN = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   fifoConnect.reader       link,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   output logic [31:0]      words_out
);

   localparam int FIFO_DEPTH = DEPTH;

   logic       inflight;
   logic       pop;
   logic       read_issue;
   logic [1:0] occ;
   logic [1:0] level;
   logic [1:0] level_after_pop;

   assign pop             = m_valid && m_ready;
   assign level           = occ + {1'b0, inflight};
   assign level_after_pop = level - {1'b0, pop};

   // Counting the in-flight word against the buffer keeps occ + inflight <= 2.
   assign read_issue = reset_n && enable && !link.fillStatus.empty
                       && (level_after_pop < 2'd2) && (FIFO_DEPTH > 0);

   assign link.read   = read_issue;
   assign link.write  = 1'b0;
   assign link.datain = '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight <= 1'b0;
      end else begin
         inflight <= read_issue;
      end
   end

   skid_buffer_2 #(
      .WIDTH(WIDTH)
   ) u_skid (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (inflight),
      .push_data (link.dataout),
      .pop       (pop),
      .head_data (m_data),
      .occ       (occ),
      .valid     (m_valid)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         words_out <= '0;
      end else if (pop) begin
         words_out <= words_out + 32'd1;
      end
   end

`ifdef FIFO_READER_BURST_EN
   localparam int              CNT_W    = burst_cnt_width(BURST_LEN);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

   logic [CNT_W-1:0] burst_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         burst_cnt <= '0;
      end else if (pop) begin
         if (burst_cnt == LAST_IDX) begin
            burst_cnt <= '0;
         end else begin
            burst_cnt <= burst_cnt + 1'b1;
         end
      end
   end

   assign m_last = m_valid && (burst_cnt == LAST_IDX);
`else
   localparam int UNUSED_BURST_LEN = BURST_LEN;

   assign m_last = (UNUSED_BURST_LEN < 0) && m_valid;
`endif

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side adapter for `fifoConnect`: drains a `fifo` instance through the interface's `reader` modport and re-presents the words as a valid/ready stream with back-pressure. It hides the FIFO's one-cycle read latency behind a 2-entry skid buffer and sustains one word per cycle. It sits between any `fifo` and a streaming consumer such as a DMA engine or packetiser, and can optionally mark burst boundaries with `m_last`.

## Interface
- `WIDTH`, 32: word width; must match the connected `fifoConnect` WIDTH.
- `DEPTH`, 32: depth of the connected FIFO; must match `fifoConnect` DEPTH.
- `BURST_LEN`, 16: words per burst for `m_last` generation; legal range ≥1.

- `clk`  in  1: single clock for the whole block.
- `reset_n`  in  1: asynchronous, active-low reset.
- `enable`  in  1: when high, the block may issue FIFO reads; when low, no new reads are issued, but in-flight words are still captured.
- `link`  `fifoConnect.reader`  —: FIFO side. Drives `read`, `write` and `datain`. Uses `dataout` and `fillStatus.empty`.
- `m_valid`  out  1: output word valid.
- `m_ready`  in  1: consumer accepts the word.
- `m_data`  out  WIDTH: output word.
- `m_last`  out  1: marks the last word of a burst.
- `words_out`  out  32: count of accepted output words; wraps modulo 2^32.

## Operation
- Fixed outputs: `link.write` = 0 and `link.datain` = 0 at all times.
- FIFO read contract: asserting `link.read` in cycle N while `fillStatus.empty`=0 returns the word on `link.dataout` in cycle N+1.
- Internal state:
  - `inflight` (0/1): a read was issued last cycle.
  - `occ` (0/1/2): skid-buffer occupancy. State machine states are BUF_EMPTY, BUF_ONE and BUF_TWO.
- Pop: `pop` = `m_valid && m_ready`.
- Read issue rule: `link.read` = `enable && !fillStatus.empty && (occ + inflight - pop) < 2`. `link.read` is combinational from registered state and `m_ready`.
- Capture: when `inflight`=1, `link.dataout` is written into the buffer tail at the clock edge.
- Output: the buffer head drives `m_data`. `m_valid` = (`occ` != 0).
- Occupancy transitions:
  - Capture with no pop: `occ`+1.
  - Pop with no capture: `occ`−1.
  - Capture and pop together: `occ` unchanged; the head advances.
  - `occ`=2 with no pop: no capture is possible, because the read rule guarantees `inflight`=0.
- Hard invariant: `occ` + `inflight` ≤ 2. Overflow of the skid buffer is impossible by construction.
- `words_out` increments on every pop.
- Stream rule: once `m_valid` is asserted, `m_data` and `m_last` hold stable until `m_ready`.

## Timing
- Reset values:
  - `m_valid`=0, `m_data`=0, `m_last`=0, `words_out`=0.
  - `link.read`=0.
  - `occ`=0, `inflight`=0, burst counter=0.
- Reset behaviour: reset asserts asynchronously and releases synchronously to `clk`. Reset mid-transfer discards buffered and in-flight words; the FIFO is expected to be reset alongside.
- Latency: a read in cycle N gives `m_valid` high in cycle N+2.
- Throughput: 1 word/cycle sustained while `m_ready`=1 and the FIFO is non-empty.
- Back-pressure:
  - `m_ready` low: at most 2 further words are read and then reads stop.
  - `m_ready` rising: reads resume in the same cycle.
- `enable` fall: reads stop that cycle. A word already in flight is still captured and delivered.
- FIFO empty: no read is issued. `m_valid` drops after the buffer drains.

## Configuration
- `FIFO_READER_BURST_EN` defined:
  - A burst counter of width $clog2(BURST_LEN) counts pops.
  - `m_last`=1 on the head word when count == BURST_LEN−1; that pop resets the counter to 0.
  - Other pops increment the counter.
  - BURST_LEN=1 gives `m_last` on every word.
- `FIFO_READER_BURST_EN` undefined: `m_last` is tied 0 and no counter logic is built.

## Structure
- The existing shared package and interface file hold `fillStatus` and `fifoConnect`; no new typedefs are added.
- One sub-module: `skid_buffer_2` (2-entry register buffer with push, pop and occupancy outputs). All read-issue logic stays in the top module.

## Test plan
- Back-to-back drain: FIFO preloaded with 0..7, `m_ready`=1, `enable`=1 → `m_data` 0..7 on 8 consecutive cycles starting 2 cycles after the first `read`; `words_out`=8.
- Back-pressure: FIFO holds 0..9, `m_ready` held low 5 cycles → exactly 2 reads issued and `m_data`=0 stable; after release, words 0..9 arrive in order with no loss or duplication.
- Empty/refill: FIFO empty, single write of 0xA5 → one read, `m_valid` high for one accepted beat with data 0xA5; no read issued while empty.
- Enable drop mid-stream: `enable` deasserted one cycle after a read → the in-flight word is still delivered and no further reads occur; re-enable resumes in order.
- Burst (`FIFO_READER_BURST_EN`, BURST_LEN=4): 12 words with random `m_ready` → `m_last` on words 3, 7, 11 only.
- Async reset: `reset_n` pulsed low mid-stream with `occ`=2 → all outputs at reset values immediately without a clock edge; `words_out`=0.
